// File: rtl/intr_ctl_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encoding, trap address.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package intr_ctl_pkg;

  localparam logic [1:0] OFF_PENDING = 2'd0;
  localparam logic [1:0] OFF_MASK    = 2'd1;
  localparam logic [1:0] OFF_CAUSE   = 2'd2;
  localparam logic [1:0] OFF_EOI     = 2'd3;

  localparam int CAUSE_VALID_BIT = 31;

  localparam logic [31:0] DEFAULT_TRAP_ADDR = 32'h0000_0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

endpackage

// File: rtl/intr_ctl_if.sv
// Core data-bus view shared by the core (master) and the interrupt controller (slave).
// Latency: n/a (wires only).
// Backpressure: none; the core samples reg_rdata during its strobe cycle.
interface intr_ctl_if;
  logic        strobe;
  logic        mem_rw;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] reg_rdata;
  logic        reg_oe;

  modport master (
    output strobe, mem_rw, d_addr, d_wdata,
    input  reg_rdata, reg_oe
  );

  modport slave (
    input  strobe, mem_rw, d_addr, d_wdata,
    output reg_rdata, reg_oe
  );
endinterface

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder over N request lines.
// Latency: combinational.
// Backpressure: none.
module intr_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [4:0]   index,
  output logic         any
);

  // Scanning downward lets the lowest set bit overwrite all others.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = 5'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctl.sv
// Interrupt controller: latches/masks/prioritises irq, raises trap, snoops the save-PC write as ack, waits for EOI.
// Latency: edge irq rise -> trap in 2 cycles (+2 with INTR_CTL_SYNC_EN); register reads are same-cycle.
// Backpressure: none; trap is held until the core acknowledges, new sources accumulate while in service.
module intr_ctl
  import intr_ctl_pkg::*;
#(
  parameter int               NIRQ      = 8,
  parameter logic [31:0]      BASE_ADDR = 32'h0000_0200,
  parameter logic [31:0]      TRAP_ADDR = DEFAULT_TRAP_ADDR,
  parameter logic [NIRQ-1:0]  EDGE_MASK = {NIRQ{1'b1}}
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NIRQ-1:0] irq,
  output logic            trap,
  intr_ctl_if.slave       bus
);

  logic [NIRQ-1:0] irq_s;

`ifdef INTR_CTL_SYNC_EN
  logic [NIRQ-1:0] sync_q1;
  logic [NIRQ-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_s = sync_q2;
`else
  assign irq_s = irq;
`endif

  state_t          state;
  logic [NIRQ-1:0] irq_prev;
  logic [NIRQ-1:0] edge_q;
  logic [NIRQ-1:0] mask_q;
  logic            cause_vld;
  logic [4:0]      cause_idx;

  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] active;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] w1c;
  logic [NIRQ-1:0] ack_clr;
  logic [4:0]      win_idx;
  logic            win_any;
  logic            hit;
  logic            wr_hit;
  logic            ack_take;
  logic            eoi;
  logic [1:0]      off;
  logic [31:0]     rd_mux;
  logic            unused_wdata;

  assign off      = bus.d_addr[1:0];
  assign hit      = bus.strobe && (bus.d_addr[31:2] == BASE_ADDR[31:2]);
  assign wr_hit   = hit && bus.mem_rw;
  assign eoi      = wr_hit && (off == OFF_EOI);
  // A save-PC write only counts as acknowledge while a trap is outstanding.
  assign ack_take = bus.strobe && bus.mem_rw && (bus.d_addr == TRAP_ADDR) && (state == REQ);

  assign rise    = irq_s & ~irq_prev;
  assign pending = (edge_q & EDGE_MASK) | (irq_s & ~EDGE_MASK);
  assign active  = pending & mask_q;
  assign w1c     = (wr_hit && (off == OFF_PENDING)) ? bus.d_wdata[NIRQ-1:0] : '0;
  assign ack_clr = (ack_take && win_any) ? (NIRQ'(1) << win_idx) : '0;
  assign unused_wdata = ^bus.d_wdata;

  intr_prio_enc #(.N(NIRQ)) u_prio_enc (
    .req   (active),
    .index (win_idx),
    .any   (win_any)
  );

  // Rise is OR-ed in last so a simultaneous set beats any clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_prev <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
    end else begin
      irq_prev <= irq_s;
      edge_q   <= ((edge_q & ~(w1c | ack_clr)) | rise) & EDGE_MASK;
      if (wr_hit && (off == OFF_MASK)) begin
        mask_q <= bus.d_wdata[NIRQ-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      trap      <= 1'b0;
      cause_vld <= 1'b0;
      cause_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|active) begin
            state <= REQ;
            trap  <= 1'b1;
          end
        end
        REQ: begin
          // Winner is taken at ack time; an empty active set records an invalid cause.
          if (ack_take) begin
            cause_vld <= win_any;
            cause_idx <= win_idx;
            trap      <= 1'b0;
            state     <= SVC;
          end
        end
        SVC: begin
          if (eoi) begin
            cause_vld <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          trap  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_PENDING: rd_mux = 32'(pending);
      OFF_MASK:    rd_mux = 32'(mask_q);
      OFF_CAUSE: begin
        rd_mux[CAUSE_VALID_BIT] = cause_vld;
        rd_mux[4:0]             = cause_idx;
      end
      default:     rd_mux = '0;
    endcase
  end

  assign bus.reg_oe    = hit && !bus.mem_rw;
  assign bus.reg_rdata = bus.reg_oe ? rd_mux : '0;

endmodule

// File: tb/tb_intr_ctl.sv
// Directed bench for intr_ctl: expected values queued as each stimulus step is driven, popped at the sample point.
// Source 2 is configured level-mode, all others edge-mode.
module tb_intr_ctl;
  import intr_ctl_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0200;
  localparam logic [31:0] TRAP = DEFAULT_TRAP_ADDR;
  localparam logic [31:0] A_PEND  = BASE + 32'd0;
  localparam logic [31:0] A_MASK  = BASE + 32'd1;
  localparam logic [31:0] A_CAUSE = BASE + 32'd2;
  localparam logic [31:0] A_EOI   = BASE + 32'd3;
  localparam logic [31:0] ALL     = 32'hFFFF_FFFF;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq     = 8'h00;
  logic       trap;

  intr_ctl_if bus_if ();

  intr_ctl #(
    .NIRQ      (8),
    .BASE_ADDR (BASE),
    .TRAP_ADDR (TRAP),
    .EDGE_MASK (8'hFB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq     (irq),
    .trap    (trap),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic check_trap(input string tag, input logic exp);
    push_exp(32'(exp));
    check(tag, 32'(trap));
  endtask

  task automatic bus_idle();
    bus_if.strobe  = 1'b0;
    bus_if.mem_rw  = 1'b0;
    bus_if.d_addr  = '0;
    bus_if.d_wdata = '0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_if.strobe  = 1'b1;
    bus_if.mem_rw  = 1'b1;
    bus_if.d_addr  = addr;
    bus_if.d_wdata = data;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] msk, input logic [31:0] exp);
    push_exp(32'd1);
    push_exp(exp);
    bus_if.strobe = 1'b1;
    bus_if.mem_rw = 1'b0;
    bus_if.d_addr = addr;
    #2;
    check({tag, "_oe"}, 32'(bus_if.reg_oe));
    check(tag, bus_if.reg_rdata & msk);
    tick();
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    bus_idle();
    reset_n = 1'b0;
    tick();
    tick();

    // Reset state
    check_trap("rst_trap", 1'b0);
    push_exp(32'd0);
    check("rst_oe", 32'(bus_if.reg_oe));
    push_exp(32'd0);
    check("rst_rdata", bus_if.reg_rdata);
    reset_n = 1'b1;
    tick();
    bus_read("rst_mask", A_MASK, ALL, 32'h0);
    bus_read("rst_pend", A_PEND, ALL, 32'h0);
    bus_read("rst_cause", A_CAUSE, ALL, 32'h0);

    // Save-PC write with nothing outstanding
    bus_write(TRAP, 32'h1234);
    check_trap("idle_ack_trap", 1'b0);

    // Edge source 3: two-cycle latency, ack, cause
    bus_write(A_MASK, 32'h08);
    irq = 8'h08;
    tick();
    check_trap("t1_trap_n1", 1'b0);
    irq = 8'h00;
    tick();
    check_trap("t1_trap_n2", 1'b1);
    bus_write(TRAP, 32'hDEAD_BEEF);
    check_trap("t1_trap_ack", 1'b0);
    bus_read("t1_cause", A_CAUSE, ALL, 32'h8000_0003);
    bus_read("t1_pend", A_PEND, ALL, 32'h0);

    // Source 1 arrives during service; signalled only after EOI
    bus_write(A_MASK, 32'h0A);
    irq = 8'h02;
    tick();
    irq = 8'h00;
    tick();
    tick();
    check_trap("t2_svc_trap", 1'b0);
    bus_read("t2_pend", A_PEND, ALL, 32'h2);
    bus_write(A_EOI, 32'h0);
    bus_read("t2_cause_vld", A_CAUSE, 32'h8000_0000, 32'h0);
    check_trap("t2_retrap", 1'b1);
    bus_write(TRAP, 32'h0);
    bus_read("t2_cause", A_CAUSE, ALL, 32'h8000_0001);
    bus_write(A_EOI, 32'h0);

    // Higher priority source 0 arriving during REQ wins
    bus_write(A_MASK, 32'h21);
    irq = 8'h20;
    tick();
    irq = 8'h00;
    tick();
    check_trap("t3_trap5", 1'b1);
    irq = 8'h01;
    tick();
    irq = 8'h00;
    tick();
    check_trap("t3_trap_held", 1'b1);
    bus_write(TRAP, 32'h0);
    bus_read("t3_cause", A_CAUSE, ALL, 32'h8000_0000);
    bus_read("t3_pend", A_PEND, ALL, 32'h20);
    bus_write(A_EOI, 32'h0);
    tick();
    check_trap("t3_retrap5", 1'b1);
    bus_write(TRAP, 32'h0);
    bus_read("t3_cause5", A_CAUSE, ALL, 32'h8000_0005);
    bus_write(A_EOI, 32'h0);

    // Level source 2 withdrawn while in REQ
    bus_write(A_MASK, 32'h04);
    irq = 8'h04;
    tick();
    check_trap("t4_trap", 1'b1);
    irq = 8'h00;
    tick();
    tick();
    check_trap("t4_trap_held", 1'b1);
    bus_write(TRAP, 32'h0);
    check_trap("t4_trap_ack", 1'b0);
    bus_read("t4_cause", A_CAUSE, ALL, 32'h0);
    bus_write(A_EOI, 32'h0);
    tick();
    tick();
    check_trap("t4_no_retrap", 1'b0);

    // Masked sources still pend; W1C on edge bits
    bus_write(A_MASK, 32'h00);
    irq = 8'hFF;
    tick();
    tick();
    check_trap("t5_masked_trap", 1'b0);
    bus_read("t5_pend_ff", A_PEND, ALL, 32'hFF);
    irq = 8'h00;
    tick();
    bus_write(A_PEND, 32'h0F);
    bus_read("t5_pend_f0", A_PEND, ALL, 32'hF0);
    check_trap("t5_trap", 1'b0);

    // Reset taken while in REQ
    bus_write(A_MASK, 32'h10);
    tick();
    check_trap("t6_trap", 1'b1);
    reset_n = 1'b0;
    tick();
    check_trap("t6_rst_trap", 1'b0);
    push_exp(32'd0);
    check("t6_rst_oe", 32'(bus_if.reg_oe));
    push_exp(32'd0);
    check("t6_rst_rdata", bus_if.reg_rdata);
    reset_n = 1'b1;
    tick();
    bus_read("t6_mask", A_MASK, ALL, 32'h0);
    bus_read("t6_cause", A_CAUSE, ALL, 32'h0);
    bus_read("t6_pend", A_PEND, ALL, 32'h0);
    tick();
    check_trap("t6_trap_after", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
